// File: rtl/gpzda_field_parser.sv
// ============================================================================
// Module   : gpzda_field_parser
// Purpose  : Parses the ZDA sentence body after header match into BCD UTC
//            time/date; define GPZDA_CHECKSUM_EN to verify the "*CS" field.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gpzda_field_parser #(
   parameter int         B         = 8,
   parameter logic [7:0] CSUM_INIT = 8'h48,
   parameter int         GAP_LIMIT = 1_000_000
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [B-1:0] data,
   input  logic         header_match,
   output logic [7:0]   hour,
   output logic [7:0]   minute,
   output logic [7:0]   second,
   output logic [7:0]   day,
   output logic [7:0]   month,
   output logic [15:0]  year,
   output logic         valid,
   output logic         error,
   output logic         busy
);

   localparam int GW = $clog2(GAP_LIMIT + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_SEP0, S_TIME, S_FRAC, S_DAY, S_MON, S_YEAR, S_SKIP, S_CS_HI, S_CS_LO
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [23:0]     r_time_sh;
   logic [7:0]      r_day_sh, r_mon_sh;
   logic [15:0]     r_year_sh;
   logic [2:0]      r_cnt, w_limit;
   logic [GW-1:0]   r_gap;
   logic            w_err, w_acc, w_shift, w_cnt_clr, w_gap_hit, w_is_digit;
   logic [3:0]      w_nib;

   assign w_is_digit = (data >= "0") && (data <= "9");
   assign w_nib      = data[3:0];
   assign w_gap_hit  = (r_state != S_IDLE) && !load && (r_gap == GW'(GAP_LIMIT - 1));
   assign busy       = (r_state != S_IDLE);

`ifdef GPZDA_CHECKSUM_EN
   logic [7:0] r_xor;
   logic [3:0] r_cs_hi, w_hex;
   logic       w_is_hex, w_cs_hi_ld;
   assign w_is_hex = w_is_digit || ((data >= "A") && (data <= "F"));
   assign w_hex    = w_is_digit ? w_nib : (w_nib + 4'd9);
`else
   logic w_unused_csum;
   assign w_unused_csum = ^CSUM_INIT;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_err       = 1'b0;
      w_acc       = 1'b0;
      w_shift     = 1'b0;
      w_cnt_clr   = 1'b0;
`ifdef GPZDA_CHECKSUM_EN
      w_cs_hi_ld  = 1'b0;
`endif
      case (r_state)
         S_TIME:         w_limit = 3'd6;
         S_DAY, S_MON:   w_limit = 3'd2;
         S_YEAR:         w_limit = 3'd4;
         default:        w_limit = 3'd0;
      endcase

      // A fresh header always wins and restarts silently, even mid-sentence
      if (header_match) begin
         w_state_nxt = S_SEP0;
         w_cnt_clr   = 1'b1;
      end else if (r_state != S_IDLE) begin
         if (load) begin
            if (data == "$") begin
               w_err = 1'b1;
            end else begin
               case (r_state)
                  S_SEP0: begin
                     if (data == ",") begin
                        w_state_nxt = S_TIME;
                        w_cnt_clr   = 1'b1;
                     end else begin
                        w_err = 1'b1;
                     end
                  end
                  S_TIME, S_DAY, S_MON, S_YEAR: begin
                     if (w_is_digit && (r_cnt != w_limit)) begin
                        w_shift = 1'b1;
                     end else if (r_cnt != w_limit) begin
                        w_err = 1'b1;
                     end else if ((r_state == S_TIME) && (data == ".")) begin
                        w_state_nxt = S_FRAC;
                     end else if (data == ",") begin
                        w_cnt_clr = 1'b1;
                        if (r_state == S_TIME)     w_state_nxt = S_DAY;
                        else if (r_state == S_DAY) w_state_nxt = S_MON;
                        else if (r_state == S_MON) w_state_nxt = S_YEAR;
                        else                       w_state_nxt = S_SKIP;
                     end else begin
                        w_err = 1'b1;
                     end
                  end
                  S_FRAC: begin
                     if (data == ",") begin
                        w_state_nxt = S_DAY;
                        w_cnt_clr   = 1'b1;
                     end else if (!w_is_digit) begin
                        w_err = 1'b1;
                     end
                  end
                  S_SKIP: begin
                     if (data == "*") begin
`ifdef GPZDA_CHECKSUM_EN
                        w_state_nxt = S_CS_HI;
`else
                        w_acc       = 1'b1;
                        w_state_nxt = S_IDLE;
`endif
                     end
                  end
`ifdef GPZDA_CHECKSUM_EN
                  S_CS_HI: begin
                     if (w_is_hex) begin
                        w_cs_hi_ld  = 1'b1;
                        w_state_nxt = S_CS_LO;
                     end else begin
                        w_err = 1'b1;
                     end
                  end
                  S_CS_LO: begin
                     if (w_is_hex && ({r_cs_hi, w_hex} == r_xor)) begin
                        w_acc       = 1'b1;
                        w_state_nxt = S_IDLE;
                     end else begin
                        w_err = 1'b1;
                     end
                  end
`endif
                  default: w_state_nxt = S_IDLE;
               endcase
            end
         end else if (w_gap_hit) begin
            w_err = 1'b1;
         end
         if (w_err) w_state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_gap     <= '0;
         r_time_sh <= '0;
         r_day_sh  <= '0;
         r_mon_sh  <= '0;
         r_year_sh <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_cnt_clr)    r_cnt <= '0;
         else if (w_shift) r_cnt <= r_cnt + 3'd1;
         if ((r_state == S_IDLE) || load || header_match || w_gap_hit) r_gap <= '0;
         else                                                          r_gap <= r_gap + GW'(1);
         if (w_shift) begin
            case (r_state)
               S_TIME:  r_time_sh <= {r_time_sh[19:0], w_nib};
               S_DAY:   r_day_sh  <= {r_day_sh[3:0], w_nib};
               S_MON:   r_mon_sh  <= {r_mon_sh[3:0], w_nib};
               default: r_year_sh <= {r_year_sh[11:0], w_nib};
            endcase
         end
      end
   end

`ifdef GPZDA_CHECKSUM_EN
   // Checksum covers every byte after the header up to, not including, '*'
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_xor   <= '0;
         r_cs_hi <= '0;
      end else begin
         if (header_match)
            r_xor <= CSUM_INIT;
         else if (load && (r_state != S_IDLE) && (r_state != S_CS_HI) &&
                  (r_state != S_CS_LO) && (data != "*"))
            r_xor <= r_xor ^ data;
         if (w_cs_hi_ld) r_cs_hi <= w_hex;
      end
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hour   <= '0;
         minute <= '0;
         second <= '0;
         day    <= '0;
         month  <= '0;
         year   <= '0;
         valid  <= 1'b0;
         error  <= 1'b0;
      end else begin
         if (w_acc) begin
            hour   <= r_time_sh[23:16];
            minute <= r_time_sh[15:8];
            second <= r_time_sh[7:0];
            day    <= r_day_sh;
            month  <= r_mon_sh;
            year   <= r_year_sh;
         end
         valid <= w_acc;
         error <= w_err;
      end
   end

endmodule

`default_nettype wire
